// File: rtl/codebreak_ctrl.sv
// codebreak_ctrl: loads ciphertext over UART, launches the codebreaker, optionally echoes plaintext over UART.
// Ports: clk/rst (async active-high); rx_data/rx_valid/rx_ack byte capture; start -> cb_start pulse;
// cb_done/cb_error/plaintext from the codebreaker; ciphertext register out; tx_data/tx_send/tx_busy echo
// handshake; byte_cnt and loaded/busy/done/error status.
// Define CODEBREAK_CTRL_TX_ECHO_EN to add the SEND state that transmits the plaintext MSB byte first.
module codebreak_ctrl #(
  parameter logic [127:0] DEFAULT_CT = 128'ha13a3ab3071897088f3233a58d6238bb,
  parameter int NUM_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ack,
  input  logic         start,
  output logic         cb_start,
  input  logic         cb_done,
  input  logic         cb_error,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic [7:0]   tx_data,
  output logic         tx_send,
  input  logic         tx_busy,
  output logic [3:0]   byte_cnt,
  output logic         loaded,
  output logic         busy,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {
    LOAD, READY, RUN,
`ifdef CODEBREAK_CTRL_TX_ECHO_EN
    SEND,
`endif
    FINISH, FAIL
  } state_t;
  state_t state, state_n;
  logic idle, go, cap, last, tx_end;
`ifdef CODEBREAK_CTRL_TX_ECHO_EN
  localparam state_t AFTER_RUN = SEND;
  logic [127:0] pt_q;
  logic [3:0] tx_idx;
  logic tx_wait;
  assign tx_end = state == SEND && tx_wait && !tx_busy && tx_idx == 4'hf;
`else
  localparam state_t AFTER_RUN = FINISH;
  logic unused_echo;
  assign unused_echo = ^{tx_busy, plaintext};
  assign tx_end = 1'b0;
  assign tx_send = 1'b0;
  assign tx_data = 8'h00;
`endif
  assign idle = state == READY || state == FINISH || state == FAIL;
  // start wins over a pending byte, which then waits un-acked until the run ends
  assign go = start && idle;
  assign cap = rx_valid && !rx_ack && !go && (idle || state == LOAD);
  assign last = state == LOAD && byte_cnt == 4'(NUM_BYTES - 1);
  assign busy = state == RUN
`ifdef CODEBREAK_CTRL_TX_ECHO_EN
    || state == SEND
`endif
    ;
  assign done = state == FINISH;
  assign error = state == FAIL;
  always_comb begin
    state_n = go ? RUN :
              cap ? (last ? READY : LOAD) :
              (state == RUN && cb_error) ? FAIL :
              (state == RUN && cb_done) ? AFTER_RUN :
              tx_end ? FINISH : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= READY;
      ciphertext <= DEFAULT_CT;
      byte_cnt <= 4'd0;
      loaded <= 1'b1;
      rx_ack <= 1'b0;
      cb_start <= 1'b0;
    end else begin
      state <= state_n;
      rx_ack <= cap;
      cb_start <= go;
      if (cap) begin
        ciphertext <= {ciphertext[119:0], rx_data};
        byte_cnt <= (state == LOAD ? byte_cnt : 4'd0) + 4'd1;
        loaded <= last;
      end
    end
  end
`ifdef CODEBREAK_CTRL_TX_ECHO_EN
  // pt_q shifts left as bytes go out, so its top byte is always the next to send
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q <= 128'd0;
      tx_idx <= 4'd0;
      tx_wait <= 1'b0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else if (state == RUN && state_n != RUN) begin
      pt_q <= plaintext;
      tx_idx <= 4'd0;
      tx_wait <= 1'b0;
      tx_send <= 1'b0;
    end else if (state == SEND) begin
      if (!tx_send && !tx_wait && !tx_busy) begin
        tx_data <= pt_q[127:120];
        pt_q <= {pt_q[119:0], 8'h00};
        tx_send <= 1'b1;
      end else if (tx_send && tx_busy) begin
        tx_send <= 1'b0;
        tx_wait <= 1'b1;
      end else if (tx_wait && !tx_busy) begin
        tx_wait <= 1'b0;
        tx_idx <= tx_idx + 4'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_codebreak_ctrl.sv
// tb_codebreak_ctrl: vector table, directed corner sequences and a randomized run against a byte-queue model.
module tb_codebreak_ctrl;
  localparam logic [127:0] DCT = 128'ha13a3ab3071897088f3233a58d6238bb;
  localparam int M_LOAD = 0, M_READY = 1, M_RUN = 2, M_FINISH = 3, M_FAIL = 4;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ack, start = 0, cb_start, cb_done = 0, cb_error = 0;
  logic [127:0] plaintext = 0, ciphertext;
  logic tx_send, tx_busy = 0, loaded, busy, done, error;
  logic [3:0] byte_cnt;
  int checks = 0, passes = 0, acks = 0;
  int m_mode, m_cnt;
  logic m_loaded, m_ack, m_cbs;
  logic [7:0] m_q[$];
  codebreak_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .start(start), .cb_start(cb_start), .cb_done(cb_done), .cb_error(cb_error),
    .plaintext(plaintext), .ciphertext(ciphertext), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .byte_cnt(byte_cnt), .loaded(loaded), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [7:0] d; logic s, cd, ce;
    logic ack, cbs, bsy, dn, er, ld; logic [3:0] cnt;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; rx_valid = 0; start = 0; cb_done = 0; cb_error = 0; tx_busy = 0;
    tick();
    chk("reset", {ciphertext, byte_cnt, loaded, busy, done, error, rx_ack, cb_start, tx_send, tx_data},
        {DCT, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_valid = 1; rx_data = b;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (rx_ack) begin got = 1; acks++; end
    end
    if (!got) chk("ack_timeout", 0, 1);
    rx_valid = 0;
    tick();
    chk("ack_one_cycle", rx_ack, 0);
  endtask
  function automatic logic [127:0] pack();
    logic [127:0] r = 0;
    foreach (m_q[i]) r = {r[119:0], m_q[i]};
    return r;
  endfunction
  task automatic model_reset();
    logic [127:0] c = DCT;
    m_q = {};
    for (int i = 15; i >= 0; i--) m_q.push_back(c[i*8 +: 8]);
    m_mode = M_READY; m_cnt = 0; m_loaded = 1; m_ack = 0; m_cbs = 0;
  endtask
  // Rules: start from an idle state launches a run; otherwise an un-acked byte is appended to the
  // last-16-bytes window; a run ends in FAIL on error, else FINISH on done.
  task automatic model_step(input logic v, input logic [7:0] d, input logic s, cd, ce);
    bit idle, go, cap;
    idle = m_mode == M_READY || m_mode == M_FINISH || m_mode == M_FAIL;
    go = s && idle;
    cap = v && !m_ack && !go && (idle || m_mode == M_LOAD);
    m_ack = cap; m_cbs = go;
    if (go) m_mode = M_RUN;
    else if (cap) begin
      m_q.push_back(d);
      void'(m_q.pop_front());
      if (m_mode != M_LOAD) begin m_cnt = 0; m_loaded = 0; end
      m_cnt++;
      if (m_cnt == 16) begin m_cnt = 0; m_loaded = 1; m_mode = M_READY; end
      else m_mode = M_LOAD;
    end else if (m_mode == M_RUN) m_mode = ce ? M_FAIL : cd ? M_FINISH : M_RUN;
  endtask
  initial begin
    tbl[0] = '{0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4'd0};
    tbl[1] = '{0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'd0};
    tbl[2] = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 1, 1, 4'd0};
    tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4'd0};
    tbl[4] = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 1, 4'd0};
    tbl[5] = '{1, 8'hAA, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd1};
    tbl[6] = '{1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1};
    tbl[7] = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1};
    tbl[8] = '{1, 8'hBB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd2};
    #2;
    do_reset();
`ifndef CODEBREAK_CTRL_TX_ECHO_EN
    foreach (tbl[i]) begin
      rx_valid = tbl[i].v; rx_data = tbl[i].d; start = tbl[i].s; cb_done = tbl[i].cd; cb_error = tbl[i].ce;
      tick();
      chk($sformatf("vec%0d", i), {rx_ack, cb_start, busy, done, error, loaded, byte_cnt},
          {tbl[i].ack, tbl[i].cbs, tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].ld, tbl[i].cnt});
    end
    chk("vec_ct", ciphertext[15:0], 16'hAABB);
    rx_valid = 0; start = 0; cb_done = 0; cb_error = 0;
`endif
    do_reset();
    acks = 0;
    for (int b = 0; b < 16; b++) begin
      send_byte(8'(b));
      if (b == 14) chk("load_15", {byte_cnt, loaded}, {4'd15, 1'b0});
    end
    chk("load_ct", ciphertext, 128'h000102030405060708090a0b0c0d0e0f);
    chk("load_flags", {byte_cnt, loaded, busy}, {4'd0, 1'b1, 1'b0});
    chk("load_acks", acks, 16);
    do_reset();
    for (int b = 0; b < 5; b++) send_byte(8'hC0 + 8'(b));
    chk("abort_5", {byte_cnt, loaded}, {4'd5, 1'b0});
    #2 rst = 1;
    #1 chk("abort_async", {ciphertext, byte_cnt, loaded}, {DCT, 4'd0, 1'b1});
    @(posedge clk); #1 rst = 0;
    tick();
    chk("abort_ready", {ciphertext, byte_cnt, loaded, busy, done, error}, {DCT, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    start = 1; tick(); start = 0;
    chk("abort_start", {cb_start, busy}, 2'b11);
    cb_error = 1; tick(); cb_error = 0;
    chk("abort_fail", {error, busy}, 2'b10);
    for (int b = 0; b < 3; b++) send_byte(8'h30 + 8'(b));
    start = 1; tick(); start = 0;
    chk("start_in_load", {cb_start, busy, byte_cnt}, {1'b0, 1'b0, 4'd3});
    do_reset();
    start = 1; rx_valid = 1; rx_data = 8'h5A;
    tick(); start = 0;
    chk("contend_start", {cb_start, rx_ack}, 2'b10);
    tick(); tick();
    chk("contend_run", {rx_ack, busy}, 2'b01);
`ifndef CODEBREAK_CTRL_TX_ECHO_EN
    cb_done = 1; tick(); cb_done = 0;
    chk("contend_finish", {done, rx_ack}, 2'b10);
`else
    cb_error = 1; tick(); cb_error = 0;
    chk("contend_fail", {error, rx_ack}, 2'b10);
`endif
    tick(); rx_valid = 0;
    chk("contend_cap", {rx_ack, byte_cnt, loaded, done, error, ciphertext[7:0]}, {1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h5A});
`ifdef CODEBREAK_CTRL_TX_ECHO_EN
    do_reset();
    plaintext = 128'h4142434445464748494a4b4c4d4e4f50;
    start = 1; tick(); start = 0;
    cb_done = 1; tick(); cb_done = 0;
    chk("echo_busy", busy, 1);
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 20 && !tx_send; k++) tick();
      chk("echo_send", tx_send, 1);
      chk($sformatf("echo_byte%0d", n), tx_data, 8'h41 + 8'(n));
      tick(); tick();
      chk("echo_hold", tx_send, 1);
      tx_busy = 1; tick();
      chk("echo_drop", tx_send, 0);
      tick(); tick();
      chk("echo_wait", {tx_send, done}, 2'b00);
      tx_busy = 0;
    end
    tick();
    chk("echo_done", {done, busy}, 2'b10);
`endif
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!rx_valid && $urandom_range(3) == 0) begin rx_valid = 1; rx_data = 8'($urandom); end
      start = $urandom_range(9) == 0;
`ifndef CODEBREAK_CTRL_TX_ECHO_EN
      cb_done = m_mode == M_RUN && $urandom_range(3) == 0;
`endif
      cb_error = m_mode == M_RUN && $urandom_range(7) == 0;
      model_step(rx_valid, rx_data, start, cb_done, cb_error);
      tick();
      chk("random", {ciphertext, byte_cnt, rx_ack, cb_start, busy, done, error, loaded},
          {pack(), 4'(m_cnt), m_ack, m_cbs, m_mode == M_RUN, m_mode == M_FINISH, m_mode == M_FAIL, m_loaded});
      if (rx_ack) rx_valid = 0;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/codebreak_ctrl.md
CODEBREAK_CTRL -- requirements
Module: codebreak_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_CT, default 128'ha13a3ab3071897088f3233a58d6238bb, which is the ciphertext loaded at reset.
REQ-002 SHALL have parameter NUM_BYTES, default 16, which is the bytes per ciphertext/plaintext block; only the value 16 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8 bits: byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: receiver byte available, held until acknowledged.
REQ-007 SHALL have port rx_ack, output, 1 bit: one-cycle acknowledge of the captured byte.
REQ-008 SHALL have port start, input, 1 bit: single-cycle start pulse (debounced button edge).
REQ-009 SHALL have port cb_start, output, 1 bit: one-cycle start pulse to the codebreaker.
REQ-010 SHALL have ports cb_done and cb_error, inputs, 1 bit each: codebreaker completion and failure.
REQ-011 SHALL have port plaintext, input, 128 bits: codebreaker output.
REQ-012 SHALL have port ciphertext, output, 128 bits: registered ciphertext driven to the codebreaker and the displays.
REQ-013 SHALL have ports tx_data (output, 8 bits), tx_send (output, 1 bit) and tx_busy (input, 1 bit): the UART transmitter handshake.
REQ-014 SHALL have port byte_cnt, output, 4 bits: bytes captured into the current load.
REQ-015 SHALL have ports loaded, busy, done and error, outputs, 1 bit each: status flags.

Function
REQ-016 SHALL implement states LOAD, READY, RUN, SEND, FINISH and FAIL.
REQ-017 SHALL capture a byte when rx_valid=1 and rx_ack=0 in any of LOAD, READY, FINISH or FAIL:
- ciphertext <= {ciphertext[119:0], rx_data}, so the first byte received ends in [127:120];
- rx_ack=1 on the following cycle only.
REQ-018 SHALL, on a capture in READY, FINISH or FAIL, clear byte_cnt before counting that byte, clear loaded, done and error, and enter LOAD.
REQ-019 SHALL increment byte_cnt per capture in LOAD; on the 16th byte, byte_cnt wraps to 0, loaded=1, and the state goes to READY.
REQ-020 SHALL, on start in READY, FINISH or FAIL, pulse cb_start for exactly one cycle, clear done and error, and enter RUN.
REQ-021 SHALL ignore start in LOAD, RUN and SEND; no cb_start is produced.
REQ-022 SHALL give start priority over rx_valid when both occur in the same cycle; the byte stays un-acked and is captured after the run completes.
REQ-023 SHALL never assert rx_ack in RUN or SEND; rx_valid is held off, and bytes arriving then are the receiver's responsibility.
REQ-024 SHALL hold busy=1 exactly in RUN and SEND.
REQ-025 SHALL, in RUN:
- on cb_error, set error=1 and enter FAIL;
- on cb_done without cb_error, go per REQ-034/035;
- if both are asserted in the same cycle, take error.
REQ-026 SHALL, in FINISH, hold done=1; in FAIL, hold error=1.
REQ-027 SHALL sample plaintext when leaving RUN and hold it in a 128-bit register for transmit.
REQ-028 SHALL transmit the sampled plaintext MSB byte first ([127:120] first) using the tx handshake:
- drive tx_data and raise tx_send when tx_busy=0;
- hold tx_send until tx_busy=1, then drop it;
- wait for tx_busy=0 before the next byte.
REQ-029 SHALL enter FINISH after the 16th byte's tx_busy falls.
REQ-030 SHALL keep ciphertext unchanged outside byte capture.

Reset
REQ-031 SHALL, while rst=1, immediately set:
- state READY, ciphertext=DEFAULT_CT, byte_cnt=0;
- loaded=1, busy=0, done=0, error=0;
- rx_ack=0, cb_start=0, tx_send=0, tx_data=0, plaintext register=0.
REQ-032 SHALL abandon any load, run or transmit when rst is asserted mid-operation; no partial bytes are retained beyond the DEFAULT_CT reload.
REQ-033 SHALL resume normal operation on the first clock edge after rst deasserts.

Configuration
REQ-034 SHALL, with macro CODEBREAK_CTRL_TX_ECHO_EN defined, include the SEND state and plaintext transmit; cb_done in RUN enters SEND.
REQ-035 SHALL, with CODEBREAK_CTRL_TX_ECHO_EN undefined:
- omit SEND and the plaintext register;
- tie tx_send=0 and tx_data=8'h00 and ignore tx_busy;
- cb_done in RUN enters FINISH directly.

Verification
REQ-036 SHALL verify reset then start: ciphertext=DEFAULT_CT, one cb_start pulse, busy=1; cb_done -> done=1 (FINISH, echo off).
REQ-037 SHALL verify load: send bytes 8'h00..8'h0F with rx_valid handshakes -> ciphertext=128'h000102030405060708090a0b0c0d0e0f, byte_cnt=0, loaded=1, 16 rx_ack pulses.
REQ-038 SHALL verify abort: 5 bytes, then rst -> ciphertext=DEFAULT_CT, byte_cnt=0, state READY; start during LOAD (3 bytes in) -> no cb_start.
REQ-039 SHALL verify error priority: cb_done=1 and cb_error=1 in the same RUN cycle -> error=1, done=0; a following start -> cb_start pulse, error cleared.
REQ-040 SHALL verify echo (macro on): plaintext=128'h4142...50 -> tx_data sequence 8'h41..8'h50 (16 bytes, MSB first), each tx_send held until tx_busy=1, then done=1.
REQ-041 SHALL verify contention: start and rx_valid in the same READY cycle -> cb_start=1, rx_ack=0; the byte is acked only after FINISH, then state LOAD with byte_cnt=1.
